z8_control_unit: RTL and testbench

- Instruction sequencer for the z8 core.
- Fetches 24-bit instruction words, decodes the 8-bit opcode against the core opcode set, and steps the FETCH/DECODE/EXECUTE/WRITEBACK state encoding.
- Drives ALU operation, operand source, memory operation, register/flag write enables and the program counter.
- Sits between instruction memory and the datapath (register file, ALU, data memory) and consumes the shared instruction-set package types.

---
 rtl/z8_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_z8_control_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z8_control_unit.sv
// z8 core instruction sequencer: fetch, decode, execute and writeback
// stepping, control strobes for the datapath and program counter upkeep.

package z8_pkg;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDM  = 8'h01,
        OP_LDR  = 8'h02,
        OP_LDD  = 8'h03,
        OP_STR  = 8'h04,
        OP_STD  = 8'h05,
        OP_ADR  = 8'h06,
        OP_ADD  = 8'h07,
        OP_SBR  = 8'h08,
        OP_SBD  = 8'h09,
        OP_ANR  = 8'h0A,
        OP_AND  = 8'h0B,
        OP_ORR  = 8'h0C,
        OP_ORD  = 8'h0D,
        OP_XOR  = 8'h0E,
        OP_XOD  = 8'h0F,
        OP_CPR  = 8'h10,
        OP_CPD  = 8'h11,
        OP_JPR  = 8'h12,
        OP_JPD  = 8'h13,
        OP_JZR  = 8'h14,
        OP_JZD  = 8'h15,
        OP_JNZR = 8'h16,
        OP_JNZD = 8'h17,
        OP_JNR  = 8'h18,
        OP_JND  = 8'h19,
        OP_HALT = 8'h1A
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_CMP = 4'd6
    } alu_ops_t;

    typedef enum logic [1:0] {
        SRC_VAL = 2'd0,
        SRC_REG = 2'd1,
        SRC_MEM = 2'd2
    } data_source_t;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ops_t;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        JMP_NONE   = 3'd0,
        JMP_ALWAYS = 3'd1,
        JMP_Z      = 3'd2,
        JMP_NZ     = 3'd3,
        JMP_N      = 3'd4
    } jmp_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic negative;
        logic zero;
    } flags_t;

endpackage

module z8_control_unit
    import z8_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [23:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic [7:0]      jmp_reg_val,
    input  logic [3:0]      alu_flags_in,
    output logic [3:0]      alu_op,
    output logic [1:0]      src_sel,
    output logic [3:0]      dst_reg,
    output logic [3:0]      src_reg,
    output logic [7:0]      imm,
    output logic [1:0]      mem_op,
    output logic            reg_we,
    output logic [3:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      state,
    output logic            halted
);

    state_t       st;
    flags_t       fl;
    logic [23:0]  ir;
    logic [7:0]   ir_op;

    alu_ops_t     d_alu;
    data_source_t d_src;
    mem_ops_t     d_mem;
    logic         d_we;
    logic         d_fw;
    jmp_t         d_jmp;
    logic         d_jreg;
    logic         d_halt;

    logic         wb_we;
    logic         wb_fw;
    jmp_t         wb_jmp;
    logic         wb_jreg;
    logic         wb_halt;

    logic         taken;
    logic [7:0]   jmp_tgt;

    assign ir_op     = ir[23:16];
    assign state     = st;
    assign flags     = fl;
    assign imem_addr = pc;
    // Request only while running in FETCH; drops the instant reset asserts.
    assign imem_req  = rst_n && (st == FETCH);

    // Opcode decode into datapath controls; undefined opcodes fall to NOP.
    always_comb begin
        d_alu  = ALU_NOP;
        d_src  = SRC_VAL;
        d_mem  = MEM_NOP;
        d_we   = 1'b0;
        d_fw   = 1'b0;
        d_jmp  = JMP_NONE;
        d_jreg = 1'b0;
        d_halt = 1'b0;
        unique case (ir_op)
            OP_LDM: begin
                d_src = SRC_MEM;
                d_mem = MEM_READ;
                d_we  = 1'b1;
            end
            OP_LDR: begin
                d_src = SRC_REG;
                d_we  = 1'b1;
            end
            OP_LDD: d_we = 1'b1;
            OP_STR: begin
                d_src = SRC_REG;
                d_mem = MEM_WRITE;
            end
            OP_STD: d_mem = MEM_WRITE;
            OP_ADR, OP_ADD: begin
                d_alu = ALU_ADD;
                d_src = (ir_op == OP_ADR) ? SRC_REG : SRC_VAL;
                d_we  = 1'b1;
                d_fw  = 1'b1;
            end
            OP_SBR, OP_SBD: begin
                d_alu = ALU_SUB;
                d_src = (ir_op == OP_SBR) ? SRC_REG : SRC_VAL;
                d_we  = 1'b1;
                d_fw  = 1'b1;
            end
            OP_ANR, OP_AND: begin
                d_alu = ALU_AND;
                d_src = (ir_op == OP_ANR) ? SRC_REG : SRC_VAL;
                d_we  = 1'b1;
                d_fw  = 1'b1;
            end
            OP_ORR, OP_ORD: begin
                d_alu = ALU_OR;
                d_src = (ir_op == OP_ORR) ? SRC_REG : SRC_VAL;
                d_we  = 1'b1;
                d_fw  = 1'b1;
            end
            OP_XOR, OP_XOD: begin
                d_alu = ALU_XOR;
                d_src = (ir_op == OP_XOR) ? SRC_REG : SRC_VAL;
                d_we  = 1'b1;
                d_fw  = 1'b1;
            end
            OP_CPR, OP_CPD: begin
                d_alu = ALU_CMP;
                d_src = (ir_op == OP_CPR) ? SRC_REG : SRC_VAL;
                d_fw  = 1'b1;
            end
            OP_JPR, OP_JPD: begin
                d_jmp  = JMP_ALWAYS;
                d_jreg = (ir_op == OP_JPR);
            end
            OP_JZR, OP_JZD: begin
                d_jmp  = JMP_Z;
                d_jreg = (ir_op == OP_JZR);
            end
            OP_JNZR, OP_JNZD: begin
                d_jmp  = JMP_NZ;
                d_jreg = (ir_op == OP_JNZR);
            end
            OP_JNR, OP_JND: begin
                d_jmp  = JMP_N;
                d_jreg = (ir_op == OP_JNR);
            end
            OP_HALT: d_halt = 1'b1;
            default: ;
        endcase
    end

    // Branch resolution against the flags held before this writeback.
    always_comb begin
        taken = 1'b0;
        unique case (wb_jmp)
            JMP_ALWAYS: taken = 1'b1;
            JMP_Z:      taken = fl.zero;
            JMP_NZ:     taken = ~fl.zero;
            JMP_N:      taken = fl.negative;
            default:    taken = 1'b0;
        endcase
        jmp_tgt = wb_jreg ? jmp_reg_val : imm;
    end

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= FETCH;
            pc      <= RESET_PC;
            fl      <= '0;
            halted  <= 1'b0;
            ir      <= '0;
            alu_op  <= ALU_NOP;
            src_sel <= SRC_VAL;
            mem_op  <= MEM_NOP;
            dst_reg <= '0;
            src_reg <= '0;
            imm     <= '0;
            reg_we  <= 1'b0;
            wb_we   <= 1'b0;
            wb_fw   <= 1'b0;
            wb_jmp  <= JMP_NONE;
            wb_jreg <= 1'b0;
            wb_halt <= 1'b0;
        end else begin
            unique case (st)
                FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        st <= DECODE;
                    end
                end
                DECODE: begin
                    alu_op  <= d_alu;
                    src_sel <= d_src;
                    mem_op  <= d_mem;
                    dst_reg <= ir[15:12];
                    src_reg <= ir[11:8];
                    imm     <= ir[7:0];
                    wb_we   <= d_we;
                    wb_fw   <= d_fw;
                    wb_jmp  <= d_jmp;
                    wb_jreg <= d_jreg;
                    wb_halt <= d_halt;
                    st      <= EXECUTE;
                end
                EXECUTE: begin
                    if (mem_op == MEM_NOP || dmem_ack) begin
                        alu_op <= ALU_NOP;
                        mem_op <= MEM_NOP;
                        reg_we <= wb_we;
                        st     <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    reg_we <= 1'b0;
                    if (wb_halt) begin
                        halted <= 1'b1;
                    end else begin
                        if (wb_fw)
                            fl <= flags_t'(alu_flags_in);
                        if (taken)
                            pc <= PC_W'(jmp_tgt);
                        else
                            pc <= pc + PC_W'(1);
                        st <= FETCH;
                    end
                end
                default: st <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_z8_control_unit.sv
// Directed bench for z8_control_unit: reset, loads, compare/branch,
// memory wait states, PC wrap, illegal opcode, HALT and mid-op reset.

module tb_z8_control_unit;
    import z8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [23:0] imem_rdata;
    logic        imem_ack;
    logic        dmem_ack;
    logic [7:0]  jmp_reg_val;
    logic [3:0]  alu_flags_in;
    logic [3:0]  alu_op;
    logic [1:0]  src_sel;
    logic [3:0]  dst_reg;
    logic [3:0]  src_reg;
    logic [7:0]  imm;
    logic [1:0]  mem_op;
    logic        reg_we;
    logic [3:0]  flags;
    logic [7:0]  pc;
    logic [1:0]  state;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    z8_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .jmp_reg_val  (jmp_reg_val),
        .alu_flags_in (alu_flags_in),
        .alu_op       (alu_op),
        .src_sel      (src_sel),
        .dst_reg      (dst_reg),
        .src_reg      (src_reg),
        .imm          (imm),
        .mem_op       (mem_op),
        .reg_we       (reg_we),
        .flags        (flags),
        .pc           (pc),
        .state        (state),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full non-memory instruction from FETCH back to FETCH.
    task automatic exec(input logic [7:0] op, input logic [3:0] d,
                        input logic [3:0] s, input logic [7:0] i,
                        input logic [3:0] fl, output logic strobe);
        strobe = 1'b0;
        imem_rdata = {op, d, s, i};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        strobe |= reg_we | (mem_op != 2'd0) | (alu_op != 4'd0);
        @(negedge clk);
        strobe |= reg_we | (mem_op != 2'd0) | (alu_op != 4'd0);
        @(negedge clk);
        alu_flags_in = fl;
        strobe |= reg_we | (mem_op != 2'd0) | (alu_op != 4'd0);
        @(negedge clk);
        chk("back_to_fetch", 32'(state), 32'(FETCH));
    endtask

    initial begin
        logic [4:0] we_trace;
        logic       st;
        int         rd_cnt;
        int         we_cnt;
        logic [7:0] imm_seen;
        logic [3:0] dst_seen;
        logic       req_seen;
        logic       pc_moved;

        rst_n = 1'b0;
        imem_rdata = '0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        jmp_reg_val = 8'h00;
        alu_flags_in = 4'hF;

        // Reset and basic LDD
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_strobes", 32'({reg_we, mem_op, alu_op}), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'h1);
        chk("addr_after_rst", 32'(imem_addr), 32'h00);
        we_trace = '0;
        we_trace[0] = reg_we;
        imem_rdata = {OP_LDD, 4'h2, 4'h0, 8'h05};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        we_trace[1] = reg_we;
        chk("ldd_decode", 32'(state), 32'(DECODE));
        @(negedge clk);
        we_trace[2] = reg_we;
        chk("ldd_dst", 32'(dst_reg), 32'h2);
        chk("ldd_imm", 32'(imm), 32'h05);
        chk("ldd_src", 32'(src_sel), 32'(SRC_VAL));
        @(negedge clk);
        we_trace[3] = reg_we;
        @(negedge clk);
        we_trace[4] = reg_we;
        chk("ldd_we_trace", 32'(we_trace), 32'b01000);
        chk("ldd_pc", 32'(pc), 32'h01);
        chk("ldd_flags_kept", 32'(flags), 32'h0);

        // Compare then branches
        imem_rdata = {OP_CPD, 4'h1, 4'h0, 8'h07};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("cpd_aluop", 32'(alu_op), 32'(ALU_CMP));
        @(negedge clk);
        chk("cpd_no_we", 32'(reg_we), 32'h0);
        chk("cpd_aluop_wb", 32'(alu_op), 32'(ALU_NOP));
        alu_flags_in = 4'b0001;
        @(negedge clk);
        chk("cpd_flags", 32'(flags), 32'b0001);
        chk("cpd_pc", 32'(pc), 32'h02);
        exec(OP_JZD, 4'h0, 4'h0, 8'h40, 4'b1110, st);
        chk("jzd_pc", 32'(pc), 32'h40);
        chk("jzd_flags_kept", 32'(flags), 32'b0001);
        exec(OP_JNZD, 4'h0, 4'h0, 8'h10, 4'b1110, st);
        chk("jnzd_pc", 32'(pc), 32'h41);
        exec(OP_JND, 4'h0, 4'h0, 8'h70, 4'b1110, st);
        chk("jnd_pc", 32'(pc), 32'h42);

        // LDM with three data-memory wait states
        imem_rdata = {OP_LDM, 4'h3, 4'h0, 8'h80};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        rd_cnt = 0;
        we_cnt = 0;
        imm_seen = '0;
        dst_seen = '0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (c == 3) begin
                imm_seen = imm;
                dst_seen = dst_reg;
            end
            if (state == 2'(EXECUTE) && mem_op == 2'(MEM_READ))
                rd_cnt++;
            if (reg_we)
                we_cnt++;
            if (c == 6)
                dmem_ack = 1'b1;
        end
        chk("ldm_read_cycles", 32'(rd_cnt), 32'd4);
        chk("ldm_we_pulses", 32'(we_cnt), 32'd1);
        chk("ldm_imm", 32'(imm_seen), 32'h80);
        chk("ldm_dst", 32'(dst_seen), 32'h3);
        chk("ldm_7cyc_state", 32'(state), 32'(FETCH));
        chk("ldm_pc", 32'(pc), 32'h43);

        // PC wrap and register jump
        exec(OP_JPD, 4'h0, 4'h0, 8'hFF, 4'h0, st);
        chk("jpd_pc", 32'(pc), 32'hFF);
        exec(OP_NOP, 4'h0, 4'h0, 8'h00, 4'h0, st);
        chk("wrap_pc", 32'(pc), 32'h00);
        jmp_reg_val = 8'h33;
        exec(OP_JPR, 4'h0, 4'h5, 8'h00, 4'h0, st);
        chk("jpr_pc", 32'(pc), 32'h33);
        chk("jpr_src_reg", 32'(src_reg), 32'h5);

        // Illegal opcode then HALT
        exec(8'hE0, 4'h4, 4'h2, 8'h99, 4'b1010, st);
        chk("illegal_pc", 32'(pc), 32'h34);
        chk("illegal_strobes", 32'(st), 32'h0);
        chk("illegal_flags", 32'(flags), 32'b0001);
        imem_rdata = {OP_HALT, 16'h0000};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted", 32'(halted), 32'h1);
        req_seen = 1'b0;
        pc_moved = 1'b0;
        imem_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_seen |= imem_req;
            pc_moved |= (pc != 8'h34);
        end
        imem_ack = 1'b0;
        chk("halt_no_req", 32'(req_seen), 32'h0);
        chk("halt_pc_moved", 32'(pc_moved), 32'h0);
        chk("halt_state", 32'(state), 32'(WRITEBACK));

        // Reset in the middle of a stalled STD
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("unhalt", 32'(halted), 32'h0);
        exec(OP_NOP, 4'h0, 4'h0, 8'h00, 4'h0, st);
        chk("pre_std_pc", 32'(pc), 32'h01);
        imem_rdata = {OP_STD, 4'h0, 4'h0, 8'h90};
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("std_memop", 32'(mem_op), 32'(MEM_WRITE));
        @(negedge clk);
        chk("std_waiting", 32'(state), 32'(EXECUTE));
        #2;
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("midrst_memop", 32'(mem_op), 32'(MEM_NOP));
        chk("midrst_pc", 32'(pc), 32'h00);
        chk("midrst_req", 32'(imem_req), 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_state", 32'(state), 32'(FETCH));
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", 32'(imem_addr), 32'h00);
        exec(OP_LDD, 4'h1, 4'h0, 8'h11, 4'h0, st);
        chk("restart_pc", 32'(pc), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
